// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with x0, write bypass and busy scoreboard
//
// Parametrised register file between decode (reads, issue) and writeback (writes).
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   rd_addr     NUM_RD read addresses, port i at [i*AW +: AW]
//   rd_data     NUM_RD read data, port i at [i*XLEN +: XLEN]
//   rd_busy     busy bit of the register addressed by each read port
//   wr_en       NUM_WR write enables
//   wr_addr     NUM_WR write addresses
//   wr_data     NUM_WR write data
//   wr_clr      per write port: also clear the busy bit of wr_addr
//   iss_valid   an instruction with a destination issues this cycle
//   iss_addr    destination register of the issued instruction
//   busy_vec    busy bits of all registers, bit 0 always 0
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter int AW     = $clog2(DEPTH),
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter bit BYPASS = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*XLEN-1:0]   wr_data,
    input  logic [NUM_WR-1:0]        wr_clr,
    input  logic                     iss_valid,
    input  logic [AW-1:0]            iss_addr,
    output logic [DEPTH-1:0]         busy_vec
);

    logic [XLEN-1:0]  regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;

    // Clears are applied first and the issue set last, so a new producer
    // issued in the same cycle as the retiring one keeps the register busy.
    always_comb begin
        busy_next = busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && wr_clr[j]) begin
                busy_next[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_valid) begin
            busy_next[iss_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Ascending port order makes the higher-index port win on an address clash.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                    regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
            busy <= busy_next;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rv;

        assign ra = rd_addr[i*AW +: AW];

        always_comb begin
            rv = regs[ra];
            if (BYPASS) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) begin
                        rv = wr_data[j*XLEN +: XLEN];
                    end
                end
            end
            // x0 and reset override everything, bypass included.
            if (rst || (ra == '0)) begin
                rv = '0;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = rv;
        // Registered state only: a same-cycle clear is not forwarded.
        assign rd_busy[i] = busy[ra] & ~rst;
    end

    assign busy_vec = busy;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file for the pipelined RISC-V core, with configurable width, depth, read-port count and write-port count.
- Adds features the current core needs:
  - x0 hardwired to zero.
  - Asynchronous clear of all registers on reset.
  - Optional write-to-read bypass.
  - Per-register busy scoreboard: set at issue, cleared at writeback, so decode can detect RAW hazards.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
- XLEN, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, ≥ 2.
- AW, $clog2(DEPTH), address width (derived; do not override).
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 1, number of write ports (1..2).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads see the registered value only.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  read data; port i occupies [i*XLEN +: XLEN].
- rd_busy  out  NUM_RD  busy flag of the register addressed by read port i.
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR*AW  write addresses.
- wr_data  in  NUM_WR*XLEN  write data.
- wr_clr  in  NUM_WR  1 = this write also clears the busy bit of wr_addr.
- iss_valid  in  1  an instruction with a destination is issued this cycle.
- iss_addr  in  AW  issued destination register.
- busy_vec  out  DEPTH  busy bits of all registers; bit 0 is always 0.

Behaviour:
- Reset (rst=1, asynchronous):
  - All DEPTH registers → 0.
  - All busy bits → 0.
  - Outputs follow combinationally: rd_data = 0, rd_busy = 0, busy_vec = 0.
  - Writes and issues in the same cycle as reset are ignored.
- Reads are combinational:
  - rd_data[i] = reg[rd_addr[i]].
  - Address 0 always returns 0, including under bypass.
- Writes occur on the rising edge when wr_en[j]=1 and wr_addr[j]≠0.
  - A write to address 0 is dropped, and its wr_clr is dropped too.
- Write latency: without bypass, data is visible on reads in the cycle after the edge.
- Bypass (BYPASS=1):
  - If wr_en[j] && wr_addr[j]==rd_addr[i] && rd_addr[i]≠0, then rd_data[i]=wr_data[j] in the same cycle.
- Dual write to the same address (NUM_WR=2):
  - The higher-index port wins, for both stored data and bypass.
  - Busy is cleared if either port has wr_clr set.
- Scoreboard, per register r≠0, next busy state:
  - set if iss_valid && iss_addr==r;
  - else clear if any j with wr_en[j] && wr_clr[j] && wr_addr[j]==r;
  - else hold.
  - Set has priority over clear on the same register: the new producer supersedes the retiring one.
  - iss_valid with iss_addr=0 has no effect.
  - Re-issuing a register that is already busy keeps it busy (no counting).
- rd_busy[i] = busy[rd_addr[i]] is registered-state only.
  - It is not bypassed by a same-cycle clear; decode stalls one cycle and then sees the value via reg or bypass.
- Addresses are always < DEPTH by construction; no out-of-range handling is required.
- No X propagation: every register is defined after the first reset.

Test Plan:
- Reset: preload x5=0xDEAD via write, then pulse rst mid-cycle asynchronously → rd_data for x5 is 0 immediately; busy_vec=0.
- Write/read, BYPASS=0: write x3=5 at edge N, read port 0 reading x3 → 0 during cycle N, 5 from cycle N+1. With BYPASS=1 → 5 during cycle N.
- x0: write x0=0xFFFFFFFF with wr_clr=1 and iss_valid to x0 → all reads of x0 are 0; busy_vec[0]=0.
- Scoreboard:
  - Issue x7 → rd_busy=1 on the next cycle.
  - Writeback x7=8 with wr_clr → busy 0 on the next cycle; read returns 8.
  - Issue and writeback-clear of x7 in the same cycle → busy stays 1.
- NUM_WR=2: port0 writes x2=10 and port1 writes x2=20 on the same edge → x2=20; bypass returns 20 that cycle.
- NUM_RD=3, DEPTH=16: three ports read x1, x15 and x1 concurrently after writes 1 and 15 → rd_data = {1, 15, 1}.
